// File: rtl/ld3320_spi_reg_rd.sv
// SPI master for a single LD3320 register read: sends the read command and
// address, then clocks eight data bits in on SDO and reports them with rd_done.
module ld3320_spi_reg_rd #(
  parameter int          HALF   = 2,
  parameter logic [7:0]  RD_CMD = 8'h05
) (
  input  logic       clk_d3,
  input  logic       sys_rst,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_done,
  output logic       busy,
  output logic       CSB,
  output logic       SCK,
  output logic       SDI,
  input  logic       SDO
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    DONE
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(HALF - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  phase;
  logic [4:0]  bit_cnt;
  logic [23:0] tx;
  logic [7:0]  rx;
  logic        phase_end;
  logic        last_bit;
  logic        accept;

  assign phase_end = (phase == PHASE_LAST);
  assign last_bit  = (bit_cnt == 5'd23);

  always_ff @(posedge clk_d3 or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pin levels come straight from the state so reset reaches CSB/SCK/busy at once.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    CSB        = 1'b1;
    SCK        = 1'b1;
    SDI        = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (rd_req) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        CSB = 1'b0;
        SDI = tx[23];
        if (phase_end) state_next = LOW;
      end
      LOW: begin
        CSB = 1'b0;
        SCK = 1'b0;
        SDI = tx[23];
        if (phase_end) state_next = HIGH;
      end
      HIGH: begin
        CSB = 1'b0;
        SDI = tx[23];
        if (phase_end) state_next = last_bit ? HOLD : LOW;
      end
      HOLD: begin
        CSB = 1'b0;
        if (phase_end) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // tx shifts on each HIGH->LOW step, so tx[23] is the current bit; the low
  // byte is zero, which gives SDI=0 throughout the read phase.
  always_ff @(posedge clk_d3 or posedge sys_rst) begin
    if (sys_rst) begin
      phase   <= 8'd0;
      bit_cnt <= 5'd0;
      tx      <= 24'd0;
      rx      <= 8'd0;
      rd_data <= 8'd0;
      rd_done <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (state == IDLE || state == DONE || state_next != state || phase_end) begin
        phase <= 8'd0;
      end else begin
        phase <= phase + 8'd1;
      end
      if (accept) begin
        tx      <= {RD_CMD, rd_addr, 8'h00};
        bit_cnt <= 5'd0;
      end
      if (state == HIGH && phase_end && !last_bit) begin
        tx      <= {tx[22:0], 1'b0};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (state == LOW && phase_end && bit_cnt[4]) begin
        rx <= {rx[6:0], SDO};
      end
      if (state == HOLD && phase_end) begin
        rd_data <= rx;
        rd_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ld3320_spi_reg_rd.sv
// Self-checking bench for ld3320_spi_reg_rd: HALF=2 and HALF=1 instances, each
// with a small LD3320 slave model that answers reads from a queue of bytes.
module tb_ld3320_spi_reg_rd;

  logic       clk_d3 = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rd_req = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic       sel = 1'b0;

  logic       req0, req1;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_done0, rd_done1, busy0, busy1;
  logic       CSB0, CSB1, SCK0, SCK1, SDI0, SDI1;
  logic       SDO0 = 1'b0;
  logic       SDO1 = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk_d3 = ~clk_d3;

  assign req0 = rd_req & ~sel;
  assign req1 = rd_req & sel;

  ld3320_spi_reg_rd #(.HALF(2), .RD_CMD(8'h05)) dut (
    .clk_d3(clk_d3), .sys_rst(sys_rst), .rd_req(req0), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_done(rd_done0), .busy(busy0),
    .CSB(CSB0), .SCK(SCK0), .SDI(SDI0), .SDO(SDO0)
  );

  ld3320_spi_reg_rd #(.HALF(1), .RD_CMD(8'h05)) dut1 (
    .clk_d3(clk_d3), .sys_rst(sys_rst), .rd_req(req1), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_done(rd_done1), .busy(busy1),
    .CSB(CSB1), .SCK(SCK1), .SDI(SDI1), .SDO(SDO1)
  );

  // Slave models: load the next queued byte when CSB falls, drive its bits on
  // SCK falling edges 16..23, MSB first.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] s0_byte, s1_byte;
  int         s0_cnt, s1_cnt;

  always @(negedge CSB0 or negedge SCK0) begin
    if (SCK0 === 1'b1) begin
      s0_byte = 8'h00;
      if (q0.size() > 0) s0_byte = q0.pop_front();
      s0_cnt = 0;
    end else if (CSB0 === 1'b0) begin
      if (s0_cnt >= 16 && s0_cnt < 24) SDO0 = s0_byte[23 - s0_cnt];
      s0_cnt++;
    end
  end

  always @(negedge CSB1 or negedge SCK1) begin
    if (SCK1 === 1'b1) begin
      s1_byte = 8'h00;
      if (q1.size() > 0) s1_byte = q1.pop_front();
      s1_cnt = 0;
    end else if (CSB1 === 1'b0) begin
      if (s1_cnt >= 16 && s1_cnt < 24) SDO1 = s1_byte[23 - s1_cnt];
      s1_cnt++;
    end
  end

  logic       m_csb, m_sck, m_sdi, m_busy_s, m_done_s;
  logic [7:0] m_rd_data;
  assign m_csb     = sel ? CSB1 : CSB0;
  assign m_sck     = sel ? SCK1 : SCK0;
  assign m_sdi     = sel ? SDI1 : SDI0;
  assign m_busy_s  = sel ? busy1 : busy0;
  assign m_done_s  = sel ? rd_done1 : rd_done0;
  assign m_rd_data = sel ? rd_data1 : rd_data0;

  int          f_csb_low, f_busy, f_done, f_rise, f_timeout;
  logic [23:0] f_stream;
  logic [7:0]  f_data;

  typedef struct {
    logic       sel;
    logic [7:0] addr;
    logic [7:0] slave;
    logic [7:0] exp_data;
    int         exp_csb_low;
    int         exp_busy;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Observes one frame sample-by-sample on falling clock edges until busy drops.
  task automatic measureFrame(input logic issue, input logic hold, input logic [7:0] addr,
                              input logic [7:0] next_addr, input int poke);
    logic prev_sck;
    f_csb_low = 0; f_busy = 0; f_done = 0; f_rise = 0; f_timeout = 1;
    f_stream = 24'h0; f_data = 8'h00;
    if (issue) begin
      @(negedge clk_d3);
      rd_req  = 1'b1;
      rd_addr = addr;
      @(negedge clk_d3);
      if (!hold) rd_req = 1'b0;
      rd_addr = next_addr;
    end
    prev_sck = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (m_busy_s !== 1'b1) begin
        f_timeout = 0;
        break;
      end
      f_busy++;
      if (m_csb === 1'b0) f_csb_low++;
      if (m_done_s === 1'b1) begin
        f_done++;
        f_data = m_rd_data;
      end
      if (prev_sck === 1'b0 && m_sck === 1'b1) begin
        f_rise++;
        f_stream = {f_stream[22:0], m_sdi};
      end
      prev_sck = m_sck;
      if (poke >= 0 && c == poke) begin
        rd_req  = 1'b1;
        rd_addr = 8'h06;
      end else if (poke >= 0 && c == poke + 1) begin
        rd_req = 1'b0;
      end
      @(negedge clk_d3);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] addr, input logic [7:0] exp_data,
                            input int exp_csb, input int exp_busy);
    checkOutput({tag, ".timeout"}, f_timeout, 0);
    checkOutput({tag, ".csb_low"}, f_csb_low, exp_csb);
    checkOutput({tag, ".busy_cycles"}, f_busy, exp_busy);
    checkOutput({tag, ".sck_rises"}, f_rise, 24);
    checkOutput({tag, ".sdi_stream"}, {8'h00, f_stream}, {8'h00, 8'h05, addr, 8'h00});
    checkOutput({tag, ".done_pulses"}, f_done, 1);
    checkOutput({tag, ".rd_data"}, f_data, exp_data);
    checkOutput({tag, ".done_low_after"}, m_done_s, 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    sel = v.sel;
    if (v.sel) q1.push_back(v.slave);
    else       q0.push_back(v.slave);
    measureFrame(1'b1, 1'b0, v.addr, ~v.addr, -1);
    checkFrame(tag, v.addr, v.exp_data, v.exp_csb_low, v.exp_busy);
  endtask

  initial begin
    int falls;
    int extra;
    logic prev;

    vecs[0] = '{sel: 1'b0, addr: 8'hBF, slave: 8'h35, exp_data: 8'h35, exp_csb_low: 100, exp_busy: 101};
    vecs[1] = '{sel: 1'b0, addr: 8'h00, slave: 8'h80, exp_data: 8'h80, exp_csb_low: 100, exp_busy: 101};
    vecs[2] = '{sel: 1'b0, addr: 8'hFF, slave: 8'h01, exp_data: 8'h01, exp_csb_low: 100, exp_busy: 101};
    vecs[3] = '{sel: 1'b1, addr: 8'h11, slave: 8'hFF, exp_data: 8'hFF, exp_csb_low: 50,  exp_busy: 51};

    // Reset values
    repeat (3) @(negedge clk_d3);
    checkOutput("rst.CSB", CSB0, 1'b1);
    checkOutput("rst.SCK", SCK0, 1'b1);
    checkOutput("rst.SDI", SDI0, 1'b0);
    checkOutput("rst.busy", busy0, 1'b0);
    checkOutput("rst.rd_data", rd_data0, 8'h00);
    checkOutput("rst.rd_done", rd_done0, 1'b0);
    checkOutput("rst.CSB_half1", CSB1, 1'b1);
    sys_rst = 1'b0;
    @(negedge clk_d3);
    checkOutput("idle.CSB", CSB0, 1'b1);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);
    sel = 1'b0;

    // Request while busy is dropped, not queued
    q0.push_back(8'h35);
    measureFrame(1'b1, 1'b0, 8'hBF, 8'hBF, 30);
    checkFrame("ovl", 8'hBF, 8'h35, 100, 101);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy0 !== 1'b0 || CSB0 !== 1'b1) extra++;
      @(negedge clk_d3);
    end
    checkOutput("ovl.no_second_frame", extra, 0);
    checkOutput("ovl.rd_data_held", rd_data0, 8'h35);

    // Back-to-back with rd_req held high
    q0.push_back(8'hA5);
    q0.push_back(8'h5A);
    measureFrame(1'b1, 1'b1, 8'hB2, 8'hBA, -1);
    checkFrame("b2b1", 8'hB2, 8'hA5, 100, 101);
    @(negedge clk_d3);
    checkOutput("b2b.idle_gap_one_cycle", busy0, 1'b1);
    checkOutput("b2b.csb_low_again", CSB0, 1'b0);
    rd_req = 1'b0;
    measureFrame(1'b0, 1'b0, 8'h00, 8'h00, -1);
    checkFrame("b2b2", 8'hBA, 8'h5A, 100, 101);

    // Reset during bit 18, on the cycle SCK has just fallen for that bit
    q0.push_back(8'h77);
    q0.push_back(8'h3C);
    @(negedge clk_d3);
    rd_req = 1'b1;
    rd_addr = 8'hBF;
    @(negedge clk_d3);
    rd_req = 1'b0;
    falls = 0;
    prev = SCK0;
    for (int c = 0; c < 200 && falls < 19; c++) begin
      @(negedge clk_d3);
      if (prev === 1'b1 && SCK0 === 1'b0) falls++;
      prev = SCK0;
    end
    checkOutput("mid.reached_bit18", falls, 19);
    sys_rst = 1'b1;
    #1;
    checkOutput("mid.CSB", CSB0, 1'b1);
    checkOutput("mid.SCK", SCK0, 1'b1);
    checkOutput("mid.SDI", SDI0, 1'b0);
    checkOutput("mid.busy", busy0, 1'b0);
    checkOutput("mid.rd_data", rd_data0, 8'h00);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      if (rd_done0 !== 1'b0) extra++;
      @(negedge clk_d3);
    end
    sys_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (rd_done0 !== 1'b0) extra++;
      @(negedge clk_d3);
    end
    checkOutput("mid.no_done", extra, 0);
    measureFrame(1'b1, 1'b0, 8'hBF, 8'h00, -1);
    checkFrame("mid.recover", 8'hBF, 8'h3C, 100, 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
